mem_store_sequencer: RTL and testbench



---
 rtl/mem_store_sequencer_if.sv | 38 +++
 rtl/mem_store_sequencer.sv | 142 ++++++++++++++
 tb/tb_mem_store_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_store_sequencer_if.sv
`default_nettype none
// ============================================================================
// mem_store_sequencer_if : MEM-stage store request and DMEM write-port bundle
// Revision : 1.0
// ============================================================================
interface mem_store_sequencer_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SPLIT_CNT_WIDTH = 16
);
  logic                       req_valid_in;
  logic                       req_ready_out;
  logic [ADDR_WIDTH-1:0]      req_addr_in;
  logic [DATA_WIDTH-1:0]      req_data_in;
  logic [2:0]                 req_func_in;
  logic                       mem_en_out;
  logic                       mem_ready_in;
  logic [ADDR_WIDTH-3:0]      mem_addr_out;
  logic [DATA_WIDTH-1:0]      mem_din_out;
  logic [DATA_WIDTH/8-1:0]    mem_we_out;
  logic                       done_out;
  logic                       err_out;
  logic                       busy_out;
  logic [SPLIT_CNT_WIDTH-1:0] split_count_out;

  modport slave (
    input  req_valid_in, req_addr_in, req_data_in, req_func_in, mem_ready_in,
    output req_ready_out, mem_en_out, mem_addr_out, mem_din_out, mem_we_out,
           done_out, err_out, busy_out, split_count_out
  );

  modport master (
    output req_valid_in, req_addr_in, req_data_in, req_func_in, mem_ready_in,
    input  req_ready_out, mem_en_out, mem_addr_out, mem_din_out, mem_we_out,
           done_out, err_out, busy_out, split_count_out
  );
endinterface
`default_nettype wire

// File: rtl/mem_store_sequencer.sv
`default_nettype none
// ============================================================================
// mem_store_sequencer : splits SB/SH/SW stores into aligned word write beats
// Revision : 1.0
// ============================================================================
module mem_store_sequencer #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SPLIT_CNT_WIDTH = 16
) (
  input  wire                   clk,
  input  wire                   rst,
  mem_store_sequencer_if.slave  bus
);
  localparam int c_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-3:0]      c_ADDR_ONE  = 1;
  localparam logic [SPLIT_CNT_WIDTH-1:0] c_CNT_ONE   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t                     r_state;
  logic                       r_mem_en;
  logic [ADDR_WIDTH-3:0]      r_mem_addr;
  logic [DATA_WIDTH-1:0]      r_din;
  logic [c_BYTES-1:0]         r_we;
  logic [DATA_WIDTH-1:0]      r_hi_din;
  logic [c_BYTES-1:0]         r_hi_we;
  logic                       r_split;
  logic [SPLIT_CNT_WIDTH-1:0] r_split_cnt;

  logic                       w_legal;
  logic [c_BYTES-1:0]         w_bmask;
  logic [DATA_WIDTH-1:0]      w_dmasked;
  logic [2*c_BYTES-1:0]       w_mask;
  logic [2*DATA_WIDTH-1:0]    w_data;
  logic                       w_accept;

  always_comb begin
    w_legal   = 1'b1;
    w_bmask   = '0;
    w_dmasked = '0;
    case (bus.req_func_in)
      3'b000: begin
        w_bmask   = 4'h1;
        w_dmasked = {24'h0, bus.req_data_in[7:0]};
      end
      3'b001: begin
        w_bmask   = 4'h3;
        w_dmasked = {16'h0, bus.req_data_in[15:0]};
      end
      3'b010: begin
        w_bmask   = 4'hF;
        w_dmasked = bus.req_data_in;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Two-word window: low half is beat 0, high half is the spill into the next word.
  assign w_mask   = {{c_BYTES{1'b0}}, w_bmask} << bus.req_addr_in[1:0];
  assign w_data   = {{DATA_WIDTH{1'b0}}, w_dmasked} << {bus.req_addr_in[1:0], 3'b000};
  assign w_accept = bus.req_valid_in && (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mem_en    <= 1'b0;
      r_mem_addr  <= '0;
      r_din       <= '0;
      r_we        <= '0;
      r_hi_din    <= '0;
      r_hi_we     <= '0;
      r_split     <= 1'b0;
      r_split_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_legal) begin
              r_state    <= BEAT0;
              r_mem_en   <= 1'b1;
              r_mem_addr <= bus.req_addr_in[ADDR_WIDTH-1:2];
              r_we       <= w_mask[c_BYTES-1:0];
              r_din      <= w_data[DATA_WIDTH-1:0];
              r_hi_we    <= w_mask[2*c_BYTES-1:c_BYTES];
              r_hi_din   <= w_data[2*DATA_WIDTH-1:DATA_WIDTH];
              r_split    <= |w_mask[2*c_BYTES-1:c_BYTES];
            end else begin
              r_state <= ERR;
            end
          end
        end
        BEAT0: begin
          if (bus.mem_ready_in) begin
            if (r_split) begin
              r_state    <= BEAT1;
              r_mem_addr <= r_mem_addr + c_ADDR_ONE;
              r_we       <= r_hi_we;
              r_din      <= r_hi_din;
            end else begin
              r_state  <= IDLE;
              r_mem_en <= 1'b0;
              r_we     <= '0;
              r_din    <= '0;
            end
          end
        end
        BEAT1: begin
          if (bus.mem_ready_in) begin
            r_state  <= IDLE;
            r_mem_en <= 1'b0;
            r_we     <= '0;
            r_din    <= '0;
            if (r_split_cnt != {SPLIT_CNT_WIDTH{1'b1}})
              r_split_cnt <= r_split_cnt + c_CNT_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // done_out marks the handshake cycle of the final beat, so it follows mem_ready_in.
  assign bus.done_out        = ((r_state == BEAT0) && bus.mem_ready_in && !r_split) ||
                               ((r_state == BEAT1) && bus.mem_ready_in) ||
                               (r_state == ERR);
  assign bus.err_out         = (r_state == ERR);
  assign bus.req_ready_out   = (r_state == IDLE);
  assign bus.busy_out        = (r_state != IDLE);
  assign bus.mem_en_out      = r_mem_en;
  assign bus.mem_addr_out    = r_mem_addr;
  assign bus.mem_din_out     = r_din;
  assign bus.mem_we_out      = r_we;
  assign bus.split_count_out = r_split_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_store_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mem_store_sequencer : directed self-checking bench for mem_store_sequencer
// Revision : 1.0
// ============================================================================
module tb_mem_store_sequencer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_store_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SPLIT_CNT_WIDTH(16)) bus ();

  mem_store_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SPLIT_CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [29:0] a, input logic [3:0] we,
                          input logic [31:0] din);
    chk({tag, " en"},   {63'd0, bus.mem_en_out}, 64'd1);
    chk({tag, " addr"}, {34'd0, bus.mem_addr_out}, {34'd0, a});
    chk({tag, " we"},   {60'd0, bus.mem_we_out}, {60'd0, we});
    chk({tag, " din"},  {32'd0, bus.mem_din_out}, {32'd0, din});
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    bus.req_valid_in = 1'b1;
    bus.req_addr_in  = a;
    bus.req_data_in  = d;
    bus.req_func_in  = f;
  endtask

  task automatic drop_req();
    bus.req_valid_in = 1'b0;
    bus.req_addr_in  = 32'h0;
    bus.req_data_in  = 32'h0;
    bus.req_func_in  = 3'b111;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drop_req();
    bus.mem_ready_in = 1'b1;
    repeat (3) cyc();

    // reset state
    chk("rst en",    {63'd0, bus.mem_en_out}, 64'd0);
    chk("rst addr",  {34'd0, bus.mem_addr_out}, 64'd0);
    chk("rst din",   {32'd0, bus.mem_din_out}, 64'd0);
    chk("rst we",    {60'd0, bus.mem_we_out}, 64'd0);
    chk("rst done",  {63'd0, bus.done_out}, 64'd0);
    chk("rst err",   {63'd0, bus.err_out}, 64'd0);
    chk("rst busy",  {63'd0, bus.busy_out}, 64'd0);
    chk("rst split", {48'd0, bus.split_count_out}, 64'd0);
    rst = 1'b0;
    cyc();
    chk("idle ready", {63'd0, bus.req_ready_out}, 64'd1);

    // 1: aligned SW
    req(32'h0000_0100, 32'hDEAD_BEEF, 3'b010);
    cyc();
    drop_req();
    chk_beat("t1 b0", 30'h40, 4'b1111, 32'hDEAD_BEEF);
    chk("t1 done", {63'd0, bus.done_out}, 64'd1);
    chk("t1 err",  {63'd0, bus.err_out}, 64'd0);
    chk("t1 busy", {63'd0, bus.busy_out}, 64'd1);
    chk("t1 rdy",  {63'd0, bus.req_ready_out}, 64'd0);
    cyc();
    chk("t1 en off", {63'd0, bus.mem_en_out}, 64'd0);
    chk("t1 done off", {63'd0, bus.done_out}, 64'd0);
    chk("t1 rdy back", {63'd0, bus.req_ready_out}, 64'd1);
    chk("t1 split", {48'd0, bus.split_count_out}, 64'd0);

    // 2: SB at the top lane drops upper data bytes
    req(32'h0000_0103, 32'hFFFF_FFA5, 3'b000);
    cyc();
    drop_req();
    chk_beat("t2 b0", 30'h40, 4'b1000, 32'hA500_0000);
    chk("t2 done", {63'd0, bus.done_out}, 64'd1);
    cyc();

    // 3: SH at offset 3 splits
    req(32'h0000_0203, 32'h0000_1234, 3'b001);
    cyc();
    drop_req();
    chk_beat("t3 b0", 30'h80, 4'b1000, 32'h3400_0000);
    chk("t3 b0 done", {63'd0, bus.done_out}, 64'd0);
    cyc();
    chk_beat("t3 b1", 30'h81, 4'b0001, 32'h0000_0012);
    chk("t3 b1 done", {63'd0, bus.done_out}, 64'd1);
    cyc();
    chk("t3 split", {48'd0, bus.split_count_out}, 64'd1);
    chk("t3 idle", {63'd0, bus.busy_out}, 64'd0);

    // 4: SW at offset 2 with beat0 stalled for 3 cycles
    req(32'h0000_0302, 32'h1122_3344, 3'b010);
    bus.mem_ready_in = 1'b0;
    cyc();
    drop_req();
    for (int i = 0; i < 3; i++) begin
      chk_beat("t4 stall", 30'hC0, 4'b1100, 32'h3344_0000);
      chk("t4 stall done", {63'd0, bus.done_out}, 64'd0);
      cyc();
    end
    chk_beat("t4 stall", 30'hC0, 4'b1100, 32'h3344_0000);
    bus.mem_ready_in = 1'b1;
    #1;
    chk("t4 b0 done", {63'd0, bus.done_out}, 64'd0);
    cyc();
    chk_beat("t4 b1", 30'hC1, 4'b0011, 32'h0000_1122);
    chk("t4 b1 done", {63'd0, bus.done_out}, 64'd1);
    cyc();
    chk("t4 split", {48'd0, bus.split_count_out}, 64'd2);

    // 5: illegal funct3
    req(32'h0000_0400, 32'h5555_5555, 3'b011);
    cyc();
    drop_req();
    chk("t5 en",   {63'd0, bus.mem_en_out}, 64'd0);
    chk("t5 done", {63'd0, bus.done_out}, 64'd1);
    chk("t5 err",  {63'd0, bus.err_out}, 64'd1);
    chk("t5 rdy",  {63'd0, bus.req_ready_out}, 64'd0);
    cyc();
    chk("t5 rdy back", {63'd0, bus.req_ready_out}, 64'd1);
    chk("t5 done off", {63'd0, bus.done_out}, 64'd0);
    chk("t5 err off",  {63'd0, bus.err_out}, 64'd0);
    chk("t5 split", {48'd0, bus.split_count_out}, 64'd2);

    // 6: SW wrapping past the top word, then reset while beat1 stalls
    req(32'hFFFF_FFFE, 32'hAABB_CCDD, 3'b010);
    cyc();
    drop_req();
    chk_beat("t6 b0", 30'h3FFF_FFFF, 4'b1100, 32'hCCDD_0000);
    cyc();
    chk_beat("t6 b1", 30'h0, 4'b0011, 32'h0000_AABB);
    bus.mem_ready_in = 1'b0;
    rst = 1'b1;
    cyc();
    chk("t6 rst en",    {63'd0, bus.mem_en_out}, 64'd0);
    chk("t6 rst split", {48'd0, bus.split_count_out}, 64'd0);
    chk("t6 rst done",  {63'd0, bus.done_out}, 64'd0);
    rst = 1'b0;
    bus.mem_ready_in = 1'b1;
    cyc();
    chk("t6 rdy", {63'd0, bus.req_ready_out}, 64'd1);
    chk("t6 en",  {63'd0, bus.mem_en_out}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
